operand_issue_stage: RTL and testbench

Parametrised successor to the operand-fetch stage between pc_gen/decode and the calculation units.
- Accepts one decoded instruction per cycle over a valid/ready handshake.
- Expands immediates, reads an internal register file and tracks pending writes in a scoreboard.
- Stalls on read-after-write (RAW) hazards.
- Presents a registered operand packet to the execution units over a second valid/ready handshake.

---
 rtl/operand_issue_stage.sv | 186 ++++++++++++++++++
 tb/tb_operand_issue_stage.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_issue_stage.sv
// operand_issue_stage
//   Operand issue stage between decode and the execution units. Takes one decoded
//   instruction per cycle, expands its immediate, reads source operands from an
//   internal register file, stalls on RAW hazards tracked by a busy-bit scoreboard
//   and presents a registered operand packet downstream.
//
// Optional build macro: OPERAND_WB_BYPASS_EN
//   When defined, a source matching the current write-back takes wb_data directly
//   and ignores its busy bit, so the dependent instruction issues in the write-back
//   cycle. When undefined, operands come only from the register file and a busy
//   source stalls until the cycle after its write-back.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   in_valid / in_ready        decoded instruction handshake
//   in_type                    1=R, 2=I, 3=S, 4=U, anything else illegal
//   in_rd, in_rs1, in_rs2      register addresses
//   in_imm                     raw immediate (imm12 = [11:0], imm20 = [19:0])
//   wb_valid, wb_ad, wb_data   write-back from the execution units
//   flush                      drop the output packet and clear the scoreboard
//   out_valid / out_ready      operand packet handshake
//   out_type, out_rd, out_op1, out_op2, out_imm, out_illegal   operand packet

module operand_issue_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [5:0]      in_type,
  input  logic [AW-1:0]   in_rd,
  input  logic [AW-1:0]   in_rs1,
  input  logic [AW-1:0]   in_rs2,
  input  logic [19:0]     in_imm,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_ad,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [5:0]      out_type,
  output logic [AW-1:0]   out_rd,
  output logic [XLEN-1:0] out_op1,
  output logic [XLEN-1:0] out_op2,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal
);

  localparam logic [5:0] TypeR = 6'd1;
  localparam logic [5:0] TypeI = 6'd2;
  localparam logic [5:0] TypeS = 6'd3;
  localparam logic [5:0] TypeU = 6'd4;

  // State
  logic [XLEN-1:0] r_rf [NREG];
  logic [NREG-1:0] r_busy;
  logic            r_valid;
  logic [5:0]      r_type;
  logic [AW-1:0]   r_rd;
  logic [XLEN-1:0] r_op1;
  logic [XLEN-1:0] r_op2;
  logic [XLEN-1:0] r_imm;
  logic            r_illegal;

  // Decode
  logic            w_legal;
  logic            w_use_rs1;
  logic            w_use_rs2;
  logic            w_writes_rd;
  logic            w_wb_en;
  logic            w_rs1_blk;
  logic            w_rs2_blk;
  logic            w_hazard;
  logic            w_accept;
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  logic [31:0]     w_u32;
  logic [XLEN-1:0] w_op1;
  logic [XLEN-1:0] w_op2;
  logic [XLEN-1:0] w_imm;
  logic [AW-1:0]   w_rd;
  logic [NREG-1:0] w_busy_d;

  assign w_use_rs1   = (in_type == TypeR) || (in_type == TypeI) || (in_type == TypeS);
  assign w_use_rs2   = (in_type == TypeR) || (in_type == TypeS);
  assign w_writes_rd = (in_type == TypeR) || (in_type == TypeI) || (in_type == TypeU);
  assign w_legal     = w_use_rs1 || (in_type == TypeU);
  assign w_wb_en     = wb_valid && (wb_ad != '0);

`ifdef OPERAND_WB_BYPASS_EN
  // A source being written back this cycle is forwarded, so its busy bit is moot.
  assign w_rs1_val = (in_rs1 == '0) ? '0 :
                     (w_wb_en && (wb_ad == in_rs1)) ? wb_data : r_rf[in_rs1];
  assign w_rs2_val = (in_rs2 == '0) ? '0 :
                     (w_wb_en && (wb_ad == in_rs2)) ? wb_data : r_rf[in_rs2];
  assign w_rs1_blk = (in_rs1 != '0) && r_busy[in_rs1] && !(w_wb_en && (wb_ad == in_rs1));
  assign w_rs2_blk = (in_rs2 != '0) && r_busy[in_rs2] && !(w_wb_en && (wb_ad == in_rs2));
`else
  // Without forwarding the write lands at the edge; the dependent issues one cycle later.
  assign w_rs1_val = (in_rs1 == '0) ? '0 : r_rf[in_rs1];
  assign w_rs2_val = (in_rs2 == '0) ? '0 : r_rf[in_rs2];
  assign w_rs1_blk = (in_rs1 != '0) && r_busy[in_rs1];
  assign w_rs2_blk = (in_rs2 != '0) && r_busy[in_rs2];
`endif

  assign w_hazard = (w_use_rs1 && w_rs1_blk) || (w_use_rs2 && w_rs2_blk);
  assign in_ready = !rst && !flush && !w_hazard && (!r_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  assign w_u32 = {in_imm, 12'h000};

  // Packet formation
  always_comb begin
    w_op1 = '0;
    w_op2 = '0;
    w_imm = '0;
    w_rd  = w_writes_rd ? in_rd : '0;
    if (w_use_rs1) w_op1 = w_rs1_val;
    if (w_use_rs2) w_op2 = w_rs2_val;
    if ((in_type == TypeI) || (in_type == TypeS)) begin
      w_imm = XLEN'($signed(in_imm[11:0]));
    end else if (in_type == TypeU) begin
      w_imm = XLEN'($signed(w_u32));
    end
  end

  // Scoreboard next state; a set from an accept overrides a same-cycle clear.
  always_comb begin
    w_busy_d = r_busy;
    if (flush) begin
      w_busy_d = '0;
    end else begin
      if (w_wb_en) w_busy_d[wb_ad] = 1'b0;
      if (w_accept && w_writes_rd && (in_rd != '0)) w_busy_d[in_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
      r_busy    <= '0;
      r_valid   <= 1'b0;
      r_type    <= '0;
      r_rd      <= '0;
      r_op1     <= '0;
      r_op2     <= '0;
      r_imm     <= '0;
      r_illegal <= 1'b0;
    end else begin
      // Write-back still lands during a flush.
      if (w_wb_en) r_rf[wb_ad] <= wb_data;
      r_busy <= w_busy_d;
      if (flush) begin
        r_valid   <= 1'b0;
        r_type    <= '0;
        r_rd      <= '0;
        r_op1     <= '0;
        r_op2     <= '0;
        r_imm     <= '0;
        r_illegal <= 1'b0;
      end else if (w_accept) begin
        r_valid   <= 1'b1;
        r_type    <= in_type;
        r_rd      <= w_rd;
        r_op1     <= w_op1;
        r_op2     <= w_op2;
        r_imm     <= w_imm;
        r_illegal <= !w_legal;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid   = r_valid;
  assign out_type    = r_type;
  assign out_rd      = r_rd;
  assign out_op1     = r_op1;
  assign out_op2     = r_op2;
  assign out_imm     = r_imm;
  assign out_illegal = r_illegal;

endmodule

// File: tb/tb_operand_issue_stage.sv
// Self-checking bench for operand_issue_stage: directed scenarios followed by
// random traffic, all compared against a behavioural register-file/scoreboard model.

module tb_operand_issue_stage;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [5:0]      in_type;
  logic [AW-1:0]   in_rd;
  logic [AW-1:0]   in_rs1;
  logic [AW-1:0]   in_rs2;
  logic [19:0]     in_imm;
  logic            wb_valid;
  logic [AW-1:0]   wb_ad;
  logic [XLEN-1:0] wb_data;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [5:0]      out_type;
  logic [AW-1:0]   out_rd;
  logic [XLEN-1:0] out_op1;
  logic [XLEN-1:0] out_op2;
  logic [XLEN-1:0] out_imm;
  logic            out_illegal;

  always #5 clk = ~clk;

  operand_issue_stage #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_type    (in_type),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_imm     (in_imm),
    .wb_valid   (wb_valid),
    .wb_ad      (wb_ad),
    .wb_data    (wb_data),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_type   (out_type),
    .out_rd     (out_rd),
    .out_op1    (out_op1),
    .out_op2    (out_op2),
    .out_imm    (out_imm),
    .out_illegal(out_illegal)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic last_ready;

  // Reference model state
  logic [XLEN-1:0] m_rf [NREG];
  bit              m_busy [NREG];
  bit              m_valid;
  logic [5:0]      m_type;
  logic [AW-1:0]   m_rd;
  logic [XLEN-1:0] m_op1, m_op2, m_imm;
  bit              m_ill;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit wb_hits(input logic [AW-1:0] a);
    return wb_valid && (wb_ad == a) && (a != 0);
  endfunction

  function automatic logic [XLEN-1:0] m_read(input logic [AW-1:0] a);
    if (a == 0) return 0;
`ifdef OPERAND_WB_BYPASS_EN
    if (wb_hits(a)) return wb_data;
`endif
    return m_rf[a];
  endfunction

  function automatic bit m_blocked(input logic [AW-1:0] a);
    if (a == 0 || !m_busy[a]) return 0;
`ifdef OPERAND_WB_BYPASS_EN
    if (wb_hits(a)) return 0;
`endif
    return 1;
  endfunction

  // One clock: check in_ready before the edge, advance the model, check outputs after.
  task automatic cycle();
    bit hz, exp_ready, acc, wr;
    logic [XLEN-1:0] p_op1, p_op2, p_imm;
    logic [AW-1:0] p_rd;
    bit p_ill;
    #1;
    hz = 0; wr = 0; p_ill = 0;
    p_op1 = 0; p_op2 = 0; p_imm = 0; p_rd = 0;
    case (in_type)
      6'd1: begin
        hz = m_blocked(in_rs1) || m_blocked(in_rs2);
        p_op1 = m_read(in_rs1); p_op2 = m_read(in_rs2); p_rd = in_rd; wr = 1;
      end
      6'd2: begin
        hz = m_blocked(in_rs1);
        p_op1 = m_read(in_rs1); p_rd = in_rd; wr = 1;
        p_imm = in_imm[11] ? ({20'h0, in_imm[11:0]} | 32'hFFFFF000) : {20'h0, in_imm[11:0]};
      end
      6'd3: begin
        hz = m_blocked(in_rs1) || m_blocked(in_rs2);
        p_op1 = m_read(in_rs1); p_op2 = m_read(in_rs2);
        p_imm = in_imm[11] ? ({20'h0, in_imm[11:0]} | 32'hFFFFF000) : {20'h0, in_imm[11:0]};
      end
      6'd4: begin
        p_imm = {12'h0, in_imm} << 12; p_rd = in_rd; wr = 1;
      end
      default: p_ill = 1;
    endcase
    exp_ready = !rst && !flush && !hz && (!m_valid || out_ready);
    last_ready = in_ready;
    check("in_ready", in_ready, exp_ready);
    acc = in_valid && exp_ready;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin m_rf[i] = 0; m_busy[i] = 0; end
      m_valid = 0;
    end else begin
      if (wb_valid && wb_ad != 0) m_rf[wb_ad] = wb_data;
      if (flush) begin
        for (int i = 0; i < NREG; i++) m_busy[i] = 0;
        m_valid = 0;
      end else begin
        if (wb_valid && wb_ad != 0) m_busy[wb_ad] = 0;
        if (acc && wr && in_rd != 0) m_busy[in_rd] = 1;
        if (acc) begin
          m_valid = 1; m_type = in_type; m_rd = p_rd;
          m_op1 = p_op1; m_op2 = p_op2; m_imm = p_imm; m_ill = p_ill;
        end else if (out_ready) begin
          m_valid = 0;
        end
      end
    end
    #1;
    check("out_valid", out_valid, m_valid);
    if (m_valid) begin
      check("out_type", out_type, m_type);
      check("out_rd", out_rd, m_rd);
      check("out_op1", out_op1, m_op1);
      check("out_op2", out_op2, m_op2);
      check("out_imm", out_imm, m_imm);
      check("out_illegal", out_illegal, m_ill);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] t, input logic [AW-1:0] rd,
                       input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic [19:0] imm);
    in_valid = v; in_type = t; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
  endtask

  task automatic set_wb(input logic v, input logic [AW-1:0] ad, input logic [XLEN-1:0] d);
    wb_valid = v; wb_ad = ad; wb_data = d;
  endtask

  initial begin
    rst = 1; flush = 0; out_ready = 1;
    drive(0, 0, 0, 0, 0, 0);
    set_wb(0, 0, 0);

    // Reset
    cycle();
    cycle();
    check("rst_in_ready", last_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_type", out_type, 0);
    check("rst_out_rd", out_rd, 0);
    check("rst_out_op1", out_op1, 0);
    check("rst_out_op2", out_op2, 0);
    check("rst_out_imm", out_imm, 0);
    check("rst_out_illegal", out_illegal, 0);
    rst = 0;

    // Idle, then R x1,x2 -> x3
    cycle();
    check("idle_ready", last_ready, 1);
    check("idle_valid", out_valid, 0);
    drive(1, 1, 3, 1, 2, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    check("r_valid", out_valid, 1);
    check("r_op1", out_op1, 0);
    check("r_op2", out_op2, 0);
    check("r_rd", out_rd, 3);

    // Write-back then dependent I
    set_wb(1, 5, 32'h1234);
    cycle();
    set_wb(0, 0, 0);
    drive(1, 2, 6, 5, 0, 20'h00FFF);
    cycle();
    check("i_op1", out_op1, 32'h1234);
    check("i_imm", out_imm, 32'hFFFFFFFF);
    check("i_rd", out_rd, 6);
    drive(1, 1, 8, 6, 0, 0);
    cycle();
    check("busy6_stall", last_ready, 0);
    drive(0, 0, 0, 0, 0, 0);
    set_wb(1, 6, 32'h77);
    cycle();
    set_wb(0, 0, 0);

    // RAW stall on x7
    drive(1, 4, 7, 0, 0, 20'h12345);
    cycle();
    check("u_imm", out_imm, 32'h12345000);
    check("u_op1", out_op1, 0);
    drive(1, 1, 9, 7, 0, 0);
    cycle();
    check("raw_stall0", last_ready, 0);
    cycle();
    check("raw_stall1", last_ready, 0);
    set_wb(1, 7, 32'hAA);
    cycle();
    set_wb(0, 0, 0);
`ifdef OPERAND_WB_BYPASS_EN
    check("raw_wb_cycle_ready", last_ready, 1);
`else
    check("raw_wb_cycle_ready", last_ready, 0);
    cycle();
    check("raw_after_wb_ready", last_ready, 1);
`endif
    drive(0, 0, 0, 0, 0, 0);
    check("raw_op1", out_op1, 32'hAA);
    check("raw_rd", out_rd, 9);

    // Backpressure and back-to-back replacement
    cycle();
    out_ready = 0;
    drive(1, 2, 10, 0, 0, 20'h00123);
    cycle();
    drive(1, 1, 11, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("bp_ready", last_ready, 0);
      check("bp_valid", out_valid, 1);
      check("bp_imm", out_imm, 32'h123);
      check("bp_rd", out_rd, 10);
    end
    out_ready = 1;
    cycle();
    check("b2b_ready", last_ready, 1);
    check("b2b_valid", out_valid, 1);
    check("b2b_rd", out_rd, 11);
    drive(0, 0, 0, 0, 0, 0);
    cycle();

    // x0 rules
    set_wb(1, 0, 32'hFF);
    cycle();
    set_wb(0, 0, 0);
    drive(1, 4, 0, 0, 0, 20'h00001);
    cycle();
    drive(1, 1, 12, 0, 0, 0);
    cycle();
    check("x0_no_stall", last_ready, 1);
    check("x0_op1", out_op1, 0);
    check("x0_op2", out_op2, 0);

    // Flush with busy[3] set and a packet held
    drive(1, 2, 13, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    out_ready = 0;
    check("pre_flush_valid", out_valid, 1);
    flush = 1;
    cycle();
    flush = 0;
    check("flush_valid", out_valid, 0);
    drive(1, 1, 14, 3, 3, 0);
    cycle();
    check("flush_no_stall", last_ready, 1);
    out_ready = 1;
    drive(1, 6'd9, 5, 1, 2, 20'hABCDE);
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    check("ill_flag", out_illegal, 1);
    check("ill_rd", out_rd, 0);
    check("ill_op1", out_op1, 0);
    check("ill_type", out_type, 9);

    // Random traffic
    for (int k = 0; k < 500; k++) begin
      int r;
      r = $urandom_range(0, 9);
      drive(($urandom_range(0, 3) != 0),
            (r < 8) ? 6'(1 + (r % 4)) : ((r == 8) ? 6'd0 : 6'($urandom_range(5, 63))),
            AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
            AW'($urandom_range(0, 7)), 20'($urandom));
      set_wb(($urandom_range(0, 2) == 0), AW'($urandom_range(0, 7)), $urandom);
      flush = ($urandom_range(0, 24) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
